// File: rtl/core_pkg.sv
// Shared core types and default sizes for the integer register file.
package core_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard with per-read-port busy lookup.
import core_pkg::*;

module reg_scoreboard #(
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_en,
  input  logic [AW-1:0]          issue_rd,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_rd,
  input  logic                   flush,
  input  logic [NRD-1:0][AW-1:0] rs,
  output logic [NRD-1:0]         busy
);

  logic [NREGS-1:0] pend, pend_nxt;

  // Next pending state: flush beats a new producer, which beats a completing write.
  always_comb begin
    pend_nxt = pend;
    for (int r = 0; r < NREGS; r++) begin
      if (flush)
        pend_nxt[r] = 1'b0;
      else if (issue_en && issue_rd == AW'(r) && !(ZERO_REG != 0 && r == 0))
        pend_nxt[r] = 1'b1;
      else if (wr_en && wr_rd == AW'(r))
        pend_nxt[r] = 1'b0;
    end
  end

  // Pending bits register; reset drops every outstanding producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pend_nxt;
  end

  // A port whose register is being written this cycle has its data via bypass.
  for (genvar i = 0; i < NRD; i++) begin : g_busy
    logic byp_hit;
    assign byp_hit = (BYPASS != 0) && wr_en && (wr_rd == rs[i]);
    assign busy[i] = pend[rs[i]] & ~byp_hit;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with write-through bypass and pending-write scoreboard.
import core_pkg::*;

module reg_file_mp #(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rf_en,
  input  logic [AW-1:0]            rd,
  input  logic [XLEN-1:0]          wdata,
  input  logic [NRD-1:0][AW-1:0]   rs,
  output logic [NRD-1:0][XLEN-1:0] rdata,
  input  logic                     issue_en,
  input  logic [AW-1:0]            issue_rd,
  input  logic                     flush,
  output logic [NRD-1:0]           busy
);

  logic [NREGS-1:0][XLEN-1:0] mem;
  logic                       wr_ok;

  // r0 swallows writes when it is hardwired to zero.
  assign wr_ok = rf_en && !(ZERO_REG != 0 && rd == '0);

  // Register storage; async reset clears everything and cancels the write on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     mem     <= '0;
    else if (wr_ok) mem[rd] <= wdata;
  end

  // Per-port read: zero register first, then same-cycle forward, then storage.
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic is_zero, byp_hit;
    assign is_zero  = (ZERO_REG != 0) && (rs[i] == '0);
    assign byp_hit  = (BYPASS != 0) && rf_en && (rd == rs[i]);
    assign rdata[i] = is_zero ? '0 : byp_hit ? wdata : mem[rs[i]];
  end

  reg_scoreboard #(
    .NREGS   (NREGS),
    .NRD     (NRD),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS),
    .AW      (AW)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue_en(issue_en),
    .issue_rd(issue_rd),
    .wr_en   (rf_en),
    .wr_rd   (rd),
    .flush   (flush),
    .rs      (rs),
    .busy    (busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and random checks of reg_file_mp (bypass and non-bypass builds) against an array model.
module tb_reg_file_mp;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic rf_en, issue_en, flush;
  logic [AW-1:0] rd, issue_rd;
  logic [XLEN-1:0] wdata;
  logic [NRD-1:0][AW-1:0] rs;
  logic [NRD-1:0][XLEN-1:0] rdata_b, rdata_n;
  logic [NRD-1:0] busy_b, busy_n;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state
  logic [XLEN-1:0] mem_m [NREGS];
  bit              pend_m[NREGS];

  always #5 clk = ~clk;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .rf_en(rf_en), .rd(rd), .wdata(wdata), .rs(rs),
    .rdata(rdata_b), .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .busy(busy_b));

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rf_en(rf_en), .rd(rd), .wdata(wdata), .rs(rs),
    .rdata(rdata_n), .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .busy(busy_n));

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rdata(input int p, input bit byp);
    int a = int'(rs[p]);
    if (a == 0) return '0;
    if (byp && rf_en && int'(rd) == a) return wdata;
    return mem_m[a];
  endfunction

  function automatic logic exp_busy(input int p, input bit byp);
    int a = int'(rs[p]);
    return pend_m[a] && !(byp && rf_en && int'(rd) == a);
  endfunction

  task automatic check_all(input string tag);
    for (int p = 0; p < NRD; p++) begin
      chk({tag, "_rdata_byp"},  rdata_b[p], exp_rdata(p, 1'b1));
      chk({tag, "_rdata_nbyp"}, rdata_n[p], exp_rdata(p, 1'b0));
      chk({tag, "_busy_byp"},   XLEN'(busy_b[p]), XLEN'(exp_busy(p, 1'b1)));
      chk({tag, "_busy_nbyp"},  XLEN'(busy_n[p]), XLEN'(exp_busy(p, 1'b0)));
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      mem_m[r] = '0;
      pend_m[r] = 1'b0;
    end
  endtask

  // one clock: check current outputs, advance model on the edge using the held inputs
  task automatic cycle(input string tag);
    #1 check_all(tag);
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (flush) begin
      for (int r = 0; r < NREGS; r++) pend_m[r] = 1'b0;
    end else begin
      if (rf_en && rd != 0) pend_m[rd] = 1'b0;
      if (issue_en && issue_rd != 0) pend_m[issue_rd] = 1'b1;
    end
    if (rst_n && rf_en && rd != 0) mem_m[rd] = wdata;
    #1;
  endtask

  task automatic idle();
    rf_en = 0; rd = '0; wdata = '0; issue_en = 0; issue_rd = '0; flush = 0;
  endtask

  initial begin
    idle();
    rs = '0;
    // reset held
    rst_n = 0;
    model_reset();
    rs[0] = 5'd5; rs[1] = 5'd31;
    #3;
    chk("reset_rdata0", rdata_b[0], '0);
    chk("reset_rdata1", rdata_b[1], '0);
    chk("reset_busy", XLEN'(busy_b), '0);
    check_all("reset_hold");
    @(negedge clk);
    rst_n = 1;
    for (int a = 0; a < NREGS; a += 2) begin
      rs[0] = AW'(a); rs[1] = AW'(a + 1);
      cycle("zero_scan");
    end

    // write then read
    rf_en = 1; rd = 5'd5; wdata = 32'hDEAD_BEEF;
    cycle("wr5");
    idle(); rs[0] = 5'd5; rs[1] = 5'd6;
    #1 chk("rd5", rdata_b[0], 32'hDEAD_BEEF);
    cycle("rd5");

    // r0 hardwired
    rf_en = 1; rd = 5'd0; wdata = 32'h1234; rs[0] = 5'd0;
    cycle("wr0");
    idle(); issue_en = 1; issue_rd = 5'd0; rs[0] = 5'd0; rs[1] = 5'd0;
    #1 chk("rd0", rdata_b[0], '0);
    cycle("iss0");
    idle();
    #1 chk("busy0", XLEN'(busy_b[0]), '0);
    cycle("busy0");

    // bypass vs old value
    rf_en = 1; rd = 5'd7; wdata = 32'h1111;
    cycle("wr7a");
    idle(); rf_en = 1; rd = 5'd7; wdata = 32'hA5A5; rs[1] = 5'd7;
    #1 chk("byp_on", rdata_b[1], 32'hA5A5);
    chk("byp_off", rdata_n[1], 32'h1111);
    cycle("byp");
    idle();
    #1 chk("byp_next", rdata_n[1], 32'hA5A5);
    cycle("byp_next");

    // scoreboard
    issue_en = 1; issue_rd = 5'd3;
    cycle("iss3");
    idle(); rs[0] = 5'd3;
    #1 chk("busy3", XLEN'(busy_b[0]), 32'd1);
    rf_en = 1; rd = 5'd3; wdata = 32'h33; issue_en = 1; issue_rd = 5'd3;
    cycle("wr_iss3");
    idle();
    #1 chk("busy3_kept", XLEN'(busy_n[0]), 32'd1);
    cycle("busy3_kept");
    rf_en = 1; rd = 5'd3; wdata = 32'h34;
    cycle("wr3");
    idle();
    #1 chk("busy3_clr", XLEN'(busy_b[0]), '0);
    cycle("busy3_clr");

    // flush
    foreach (rs[k]) rs[k] = '0;
    issue_en = 1; issue_rd = 5'd3; cycle("iss3f");
    issue_rd = 5'd4; cycle("iss4f");
    issue_rd = 5'd9; cycle("iss9f");
    rs[0] = 5'd9; rs[1] = 5'd4;
    #1 chk("pre_flush", XLEN'(busy_b), 32'd3);
    flush = 1; issue_en = 1; issue_rd = 5'd4;
    cycle("flush");
    idle(); rs[0] = 5'd3; rs[1] = 5'd4;
    #1 chk("post_flush_a", XLEN'(busy_b), '0);
    cycle("post_flush_a");
    rs[0] = 5'd9;
    cycle("post_flush_b");

    // random traffic, half the addresses kept low to force collisions
    for (int n = 0; n < 400; n++) begin
      rf_en = 1'($urandom);
      rd = ($urandom % 2) ? AW'($urandom % 8) : AW'($urandom);
      wdata = $urandom;
      issue_en = 1'($urandom);
      issue_rd = ($urandom % 2) ? AW'($urandom % 8) : AW'($urandom);
      flush = ($urandom % 16) == 0;
      rs[0] = ($urandom % 2) ? AW'($urandom % 8) : AW'($urandom);
      rs[1] = ($urandom % 2) ? rs[0] : AW'($urandom % 8);
      cycle("rand");
    end

    // async reset between edges with state pending
    idle(); rf_en = 1; rd = 5'd6; wdata = 32'h6666; issue_en = 1; issue_rd = 5'd5;
    cycle("pre_rst");
    idle(); rs[0] = 5'd6; rs[1] = 5'd5;
    #1 chk("pre_rst_r6", rdata_b[0], 32'h6666);
    chk("pre_rst_busy5", XLEN'(busy_b[1]), 32'd1);
    @(negedge clk);
    #2 rst_n = 0;
    model_reset();
    #1 chk("async_rdata", rdata_b[0], '0);
    chk("async_busy", XLEN'(busy_b), '0);
    check_all("async_rst");
    rf_en = 1; rd = 5'd6; wdata = 32'hBAD0;
    @(posedge clk);
    #1 idle();
    #1 check_all("rst_held_edge");
    @(negedge clk);
    rst_n = 1;
    cycle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // bound the run regardless of what the DUT does
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
